rv_dmem_resp: RTL and testbench

Data-memory responder for the multicycle RISC-V core: the target end of the core's dmem address/write-data/read-data interface. Accepts one word-aligned load or store at a time over a req/ready handshake and applies a configurable number of wait states. Internal storage is a word array with byte-enable writes. Misaligned and out-of-range accesses are flagged as errors. Sits between the core datapath/control and the testbench or SoC memory map.

---
 rtl/rv_mem_pkg.sv | 24 ++
 rtl/rv_dmem_resp_if.sv | 30 +++
 rtl/rv_sram_1rw.sv | 42 ++++
 rtl/rv_dmem_resp.sv | 145 ++++++++++++++
 tb/tb_rv_dmem_resp.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/rv_mem_pkg.sv
// rtl/rv_mem_pkg.sv - shared types, constants and address decode for the dmem responder
// Purpose: FSM state encoding, byte-lane constants and the access error decode.
// Ports: none (package).
package rv_mem_pkg;

   localparam int XLEN          = 32;
   localparam int BE_WIDTH      = XLEN / 8;
   localparam int WORD_ADDR_LSB = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   // An access is in error when it is not word aligned or lies past the last stored word.
   // The limit is computed two bits wider so DEPTH_WORDS*4 cannot wrap.
   function automatic logic addr_err(input logic [XLEN-1:0] addr, input int depth_words);
      logic [XLEN+1:0] limit;
      limit = (XLEN+2)'(depth_words) << WORD_ADDR_LSB;
      return (addr[WORD_ADDR_LSB-1:0] != '0) || ({2'b00, addr} >= limit);
   endfunction

endpackage

// File: rtl/rv_dmem_resp_if.sv
// rtl/rv_dmem_resp_if.sv - dmem request/response bus between core and responder
// Purpose: bundles the core-side dmem handshake.
// Ports (signals): req, we, addr, wdata, be (core -> memory);
//                  rdata, ready, err, busy (memory -> core).
// Modports: master = core side, slave = memory responder side.
interface rv_dmem_resp_if #(
   parameter int DPWIDTH = 32
);

   logic                   req;
   logic                   we;
   logic [DPWIDTH-1:0]     addr;
   logic [DPWIDTH-1:0]     wdata;
   logic [DPWIDTH/8-1:0]   be;
   logic [DPWIDTH-1:0]     rdata;
   logic                   ready;
   logic                   err;
   logic                   busy;

   modport master (
      output req, we, addr, wdata, be,
      input  rdata, ready, err, busy
   );

   modport slave (
      input  req, we, addr, wdata, be,
      output rdata, ready, err, busy
   );

endinterface

// File: rtl/rv_sram_1rw.sv
// rtl/rv_sram_1rw.sv - single-port synchronous word array with byte-enable writes
// Purpose: storage behind the dmem responder; one access per cycle, no reset.
// Ports: clk   - clock
//        en    - access enable
//        we    - 1 = write enabled bytes, 0 = read
//        be    - byte enables for writes
//        addr  - word address
//        wdata - write data
//        rdata - read data, registered, valid the cycle after a read
module rv_sram_1rw
   import rv_mem_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                en,
   input  logic                we,
   input  logic [BE_WIDTH-1:0] be,
   input  logic [AW-1:0]       addr,
   input  logic [XLEN-1:0]     wdata,
   output logic [XLEN-1:0]     rdata
);

   logic [XLEN-1:0] mem [DEPTH];

   // rdata only moves on a read, so it keeps the last read word across writes.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
               if (be[i]) begin
                  mem[addr][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/rv_dmem_resp.sv
// rtl/rv_dmem_resp.sv - data-memory responder for the multicycle RISC-V core
// Purpose: accepts one load/store at a time, inserts WAIT_CYCLES wait states,
//          flags misaligned/out-of-range accesses and answers with a one-cycle ready strobe.
// Ports: clk   - clock, rising edge
//        rst_n - asynchronous active-low reset
//        bus   - dmem slave port: req/we/addr/wdata/be in, rdata/ready/err/busy out
module rv_dmem_resp
   import rv_mem_pkg::*;
#(
   parameter int DPWIDTH     = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   rv_dmem_resp_if.slave bus
);

   localparam int         AW        = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

   dmem_state_e           state;
   logic [3:0]            cnt;
   logic                  lat_we;
   logic [DPWIDTH-1:0]    lat_addr;
   logic [DPWIDTH-1:0]    lat_wdata;
   logic [BE_WIDTH-1:0]   lat_be;
   logic                  ready_q;
   logic                  err_q;
   logic                  busy_q;
   logic                  rd_valid;
   logic [DPWIDTH-1:0]    rdata_q;
   logic [DPWIDTH-1:0]    sram_rdata;

   logic                  accept;
   logic                  direct;
   logic                  wait_done;
   logic                  req_err;
   logic                  lat_err;
   logic                  write_commit;
   logic                  read_launch;
   logic                  sram_en;
   logic [AW-1:0]         sram_addr;

   always_comb begin
      accept       = (state == IDLE) && bus.req;
      // With no wait states the read has to be launched straight from the bus
      // at the accept edge so the word lands in the RESP cycle.
      direct       = accept && (WAIT_CYCLES == 0);
      wait_done    = (state == WAIT) && (cnt == 4'd0);
      req_err      = addr_err(bus.addr, DEPTH_WORDS);
      lat_err      = addr_err(lat_addr, DEPTH_WORDS);
      // Write happens at the edge ending RESP; an async reset leaves RESP first, dropping it.
      write_commit = (state == RESP) && lat_we && !lat_err;
      read_launch  = 1'b0;
      if (direct) begin
         read_launch = !bus.we && !req_err;
      end else begin
         read_launch = wait_done && !lat_we && !lat_err;
      end
      sram_en      = write_commit || read_launch;
      sram_addr    = direct ? bus.addr[AW+WORD_ADDR_LSB-1:WORD_ADDR_LSB]
                            : lat_addr[AW+WORD_ADDR_LSB-1:WORD_ADDR_LSB];
   end

   rv_sram_1rw #(
      .DEPTH (DEPTH_WORDS),
      .AW    (AW)
   ) u_sram (
      .clk   (clk),
      .en    (sram_en),
      .we    (write_commit),
      .be    (lat_be),
      .addr  (sram_addr),
      .wdata (lat_wdata),
      .rdata (sram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_be    <= '0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         rd_valid  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
         rd_valid <= read_launch;
         // Keep the freshly read word once RESP ends so rdata holds until the next good load.
         if (rd_valid) begin
            rdata_q <= sram_rdata;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  lat_we    <= bus.we;
                  lat_addr  <= bus.addr;
                  lat_wdata <= bus.wdata;
                  lat_be    <= bus.be;
                  busy_q    <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     state   <= RESP;
                     ready_q <= 1'b1;
                     err_q   <= req_err;
                  end else begin
                     state <= WAIT;
                     cnt   <= WAIT_INIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state   <= RESP;
                  ready_q <= 1'b1;
                  err_q   <= lat_err;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   // During RESP of a load the array output is the fresh word; otherwise the held copy.
   assign bus.rdata = rd_valid ? sram_rdata : rdata_q;
   assign bus.ready = ready_q;
   assign bus.err   = err_q;
   assign bus.busy  = busy_q;

endmodule

// File: tb/tb_rv_dmem_resp.sv
// tb/tb_rv_dmem_resp.sv - directed self-checking bench for rv_dmem_resp
module tb_rv_dmem_resp;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   rv_dmem_resp_if #(.DPWIDTH(32)) b2 ();
   rv_dmem_resp_if #(.DPWIDTH(32)) b0 ();

   rv_dmem_resp #(.DPWIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b2)
   );

   rv_dmem_resp #(.DPWIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b0)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic idle_inputs();
      b2.req = 0; b2.we = 0; b2.addr = '0; b2.wdata = '0; b2.be = '0;
      b0.req = 0; b0.we = 0; b0.addr = '0; b0.wdata = '0; b0.be = '0;
   endtask

   // One request on the WAIT_CYCLES=2 instance; lat is the falling edge index
   // (counted from the accept edge) where ready was seen, 0 if never.
   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] e, output logic [31:0] rd, output logic er,
                         output int lat);
      logic done;
      b2.req = 1; b2.we = w; b2.addr = a; b2.wdata = d; b2.be = e;
      @(posedge clk); #1;
      b2.req = 0; b2.we = 0;
      lat = 0; rd = '0; er = 1'b0; done = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         if (!done) begin
            @(negedge clk);
            if (b2.ready) begin
               lat = i; rd = b2.rdata; er = b2.err; done = 1'b1;
            end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (b2.ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", b2.ready); end
      checks++; if (b2.err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", b2.err); end
      checks++; if (b2.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", b2.busy); end
      checks++; if (b2.rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", b2.rdata); end
      checks++; if (b0.rdata !== 32'h0 || b0.ready !== 1'b0) begin failures++; $display("FAIL rst_w0 got=%h/%b exp=0/0", b0.rdata, b0.ready); end
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_store_load();
      logic [31:0] rd; logic er; int lat;
      access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
      checks++; if (lat !== 3) begin failures++; $display("FAIL st_latency got=%0d exp=3", lat); end
      checks++; if (er !== 1'b0) begin failures++; $display("FAIL st_err got=%b exp=0", er); end
      access(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
      checks++; if (lat !== 3) begin failures++; $display("FAIL ld_latency got=%0d exp=3", lat); end
      checks++; if (er !== 1'b0) begin failures++; $display("FAIL ld_err got=%b exp=0", er); end
      checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL ld_rdata got=%h exp=deadbeef", rd); end
      checks++; if (b2.rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL ld_hold got=%h exp=deadbeef", b2.rdata); end
      checks++; if (b2.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", b2.busy); end
   endtask

   task automatic test_byte_enables();
      logic [31:0] rd; logic er; int lat;
      access(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er, lat);
      access(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
      checks++; if (rd !== 32'hDE22BE44) begin failures++; $display("FAIL be_merge got=%h exp=de22be44", rd); end
      access(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
      checks++; if (er !== 1'b0 || lat !== 3) begin failures++; $display("FAIL be_zero_resp got=%b/%0d exp=0/3", er, lat); end
      access(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
      checks++; if (rd !== 32'hDE22BE44) begin failures++; $display("FAIL be_zero got=%h exp=de22be44", rd); end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er; int lat;
      access(1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat);
      checks++; if (er !== 1'b1 || lat !== 3) begin failures++; $display("FAIL mis_err got=%b/%0d exp=1/3", er, lat); end
      checks++; if (rd !== 32'hDE22BE44) begin failures++; $display("FAIL mis_rdata got=%h exp=de22be44", rd); end
      access(1'b1, 32'h0, 32'h01020304, 4'hF, rd, er, lat);
      access(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, er, lat);
      checks++; if (er !== 1'b1) begin failures++; $display("FAIL oor_err got=%b exp=1", er); end
      access(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
      checks++; if (rd !== 32'h01020304 || er !== 1'b0) begin failures++; $display("FAIL oor_nowrite got=%h/%b exp=01020304/0", rd, er); end
      access(1'b1, 32'hFFC, 32'h0BADCAFE, 4'hF, rd, er, lat);
      checks++; if (er !== 1'b0) begin failures++; $display("FAIL last_word_err got=%b exp=0", er); end
      access(1'b0, 32'hFFC, 32'h0, 4'h0, rd, er, lat);
      checks++; if (rd !== 32'h0BADCAFE) begin failures++; $display("FAIL last_word got=%h exp=0badcafe", rd); end
      access(1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
      checks++; if (er !== 1'b1 || rd !== 32'h0BADCAFE) begin failures++; $display("FAIL oor_load got=%b/%h exp=1/0badcafe", er, rd); end
   endtask

   task automatic test_req_while_busy();
      logic [31:0] rd; logic er; int lat;
      int pulses; logic [31:0] seen;
      b2.req = 1; b2.we = 0; b2.addr = 32'h10; b2.be = 4'h0;
      @(posedge clk); #1;
      b2.req = 1; b2.we = 1; b2.addr = 32'h0; b2.wdata = 32'h55555555; b2.be = 4'hF;
      @(posedge clk); #1;
      b2.req = 0; b2.we = 0;
      pulses = 0; seen = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (b2.ready) begin
            pulses++; seen = b2.rdata;
         end
      end
      @(posedge clk); #1;
      checks++; if (pulses !== 1) begin failures++; $display("FAIL busy_pulses got=%0d exp=1", pulses); end
      checks++; if (seen !== 32'hDE22BE44) begin failures++; $display("FAIL busy_first got=%h exp=de22be44", seen); end
      access(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
      checks++; if (rd !== 32'h01020304) begin failures++; $display("FAIL busy_ignored got=%h exp=01020304", rd); end
   endtask

   task automatic test_reset_mid_store();
      logic [31:0] rd; logic er; int lat; logic hit;
      access(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, rd, er, lat);
      b2.req = 1; b2.we = 1; b2.addr = 32'h20; b2.wdata = 32'h12345678; b2.be = 4'hF;
      @(posedge clk); #1;
      b2.req = 0; b2.we = 0;
      checks++; if (b2.busy !== 1'b1) begin failures++; $display("FAIL wait_busy got=%b exp=1", b2.busy); end
      rst_n = 0;
      #1;
      checks++; if (b2.busy !== 1'b0 || b2.ready !== 1'b0 || b2.err !== 1'b0) begin
         failures++; $display("FAIL async_rst got=%b%b%b exp=000", b2.busy, b2.ready, b2.err); end
      checks++; if (b2.rdata !== 32'h0) begin failures++; $display("FAIL async_rdata got=%h exp=0", b2.rdata); end
      repeat (2) @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
      access(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
      checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL rst_wait_nowrite got=%h exp=cafef00d", rd); end
      // Reset landing in the RESP cycle must also drop the write.
      access(1'b1, 32'h24, 32'h600DF00D, 4'hF, rd, er, lat);
      b2.req = 1; b2.we = 1; b2.addr = 32'h24; b2.wdata = 32'hBAD0BAD0; b2.be = 4'hF;
      @(posedge clk); #1;
      b2.req = 0; b2.we = 0;
      hit = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (!hit) begin
            @(negedge clk);
            if (b2.ready) hit = 1'b1;
         end
      end
      checks++; if (hit !== 1'b1) begin failures++; $display("FAIL resp_reached got=%b exp=1", hit); end
      rst_n = 0;
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
      access(1'b0, 32'h24, 32'h0, 4'h0, rd, er, lat);
      checks++; if (rd !== 32'h600DF00D) begin failures++; $display("FAIL rst_resp_nowrite got=%h exp=600df00d", rd); end
   endtask

   task automatic test_wait0();
      logic exp_pulse;
      b0.req = 1; b0.we = 1; b0.addr = 32'h10; b0.wdata = 32'hA5A5A5A5; b0.be = 4'hF;
      @(posedge clk); #1;
      b0.req = 0; b0.we = 0;
      @(negedge clk);
      checks++; if (b0.ready !== 1'b1 || b0.err !== 1'b0) begin failures++; $display("FAIL w0_store got=%b/%b exp=1/0", b0.ready, b0.err); end
      @(posedge clk); #1;
      b0.req = 1; b0.we = 0; b0.addr = 32'h10;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         exp_pulse = (i % 2 == 0);
         checks++; if (b0.ready !== exp_pulse || b0.busy !== exp_pulse) begin
            failures++; $display("FAIL w0_cycle%0d got=%b/%b exp=%b/%b", i, b0.ready, b0.busy, exp_pulse, exp_pulse); end
         if (exp_pulse) begin
            checks++; if (b0.rdata !== 32'hA5A5A5A5 || b0.err !== 1'b0) begin
               failures++; $display("FAIL w0_rdata%0d got=%h/%b exp=a5a5a5a5/0", i, b0.rdata, b0.err); end
         end
      end
      b0.req = 0;
      repeat (2) @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_byte_enables();
      test_errors();
      test_req_while_busy();
      test_reset_mid_store();
      test_wait0();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
